// File: rtl/sc_fir_sequencer.sv
// Control stage for the stochastic FIR: 39-tap sample delay line, one 2^N-cycle
// stochastic frame per sample, LFSR-driven R_y, and a valid/ready result port.
module sc_fir_sequencer #(
  parameter int             N         = 8,
  parameter logic [N-1:0]   LFSR_MASK = 8'hB8,
  parameter logic [N-1:0]   LFSR_SEED = 8'h01
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N:0]   sample_in,
  input  logic         sample_valid,
  output logic         sample_ready,
  output logic [N:0]   taps [0:38],
  output logic         start,
  output logic [N-1:0] sel_bits,
  output logic [N-1:0] R_y,
  input  logic [N:0]   acc_out,
  output logic [N:0]   result,
  output logic         result_valid,
  input  logic         result_ready
);

  localparam int TAPS = 39;

  typedef enum logic [1:0] {IDLE, START, RUN, HOLD} state_t;

  state_t       state_reg, state_next;
  logic         accept;
  logic         last_cycle;
  logic [N-1:0] lfsr_next;
  logic [N:0]   tap_shift [0:TAPS-1];

  always_ff @(posedge clock) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    sample_ready = 1'b0;
    start        = 1'b0;
    result_valid = 1'b0;
    accept       = 1'b0;
    last_cycle   = 1'b0;
    case (state_reg)
      IDLE: begin
        sample_ready = 1'b1;
        if (sample_valid) begin
          accept     = 1'b1;
          state_next = START;
        end
      end
      START: begin
        start      = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (sel_bits == '1) begin
          last_cycle = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        result_valid = 1'b1;
        if (result_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shifted view of the delay line; only committed on an IDLE accept.
  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        assign tap_shift[gi] = sample_in;
      end else begin : g_body
        assign tap_shift[gi] = taps[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < TAPS; i++) taps[i] <= '0;
    end else if (accept) begin
      taps <= tap_shift;
    end
  end

  assign lfsr_next = R_y[0] ? ((R_y >> 1) ^ LFSR_MASK) : (R_y >> 1);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sel_bits <= '0;
      R_y      <= LFSR_SEED;
      result   <= '0;
    end else begin
      case (state_reg)
        START: begin
          sel_bits <= '0;
          R_y      <= LFSR_SEED;
        end
        RUN: begin
          sel_bits <= last_cycle ? '0 : sel_bits + 1'b1;
          R_y      <= lfsr_next;
          // acc_out here counts bits from sel_bits 0..2^N-2
          if (last_cycle) result <= acc_out;
        end
        default: sel_bits <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_fir_sequencer.sv
// Randomized bench for sc_fir_sequencer: frame-level model of taps, LFSR sequence,
// frame timing and result capture, driven against a stand-in accumulator output.
module tb_sc_fir_sequencer;

  localparam int N     = 8;
  localparam int TAPS  = 39;
  localparam int FRAME = 1 << N;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [N:0]   sample_in = '0;
  logic         sample_valid = 1'b0;
  logic         sample_ready;
  logic [N:0]   taps [0:38];
  logic         start;
  logic [N-1:0] sel_bits;
  logic [N-1:0] R_y;
  logic [N:0]   acc_out = '0;
  logic [N:0]   result;
  logic         result_valid;
  logic         result_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_start = -10000;

  int model_taps [TAPS];
  int lfsr_seq   [FRAME];
  int lfsr_known [4];
  int taps3      [TAPS];

  sc_fir_sequencer #(.N(N), .LFSR_MASK(8'hB8), .LFSR_SEED(8'h01)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .taps         (taps),
    .start        (start),
    .sel_bits     (sel_bits),
    .R_y          (R_y),
    .acc_out      (acc_out),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_taps(input string tag);
    for (int i = 0; i < TAPS; i++)
      check($sformatf("%s taps[%0d]", tag, i), taps[i], model_taps[i]);
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < TAPS; i++) model_taps[i] = 0;
    check({tag, " sample_ready"}, sample_ready, 1);
    check({tag, " start"}, start, 0);
    check({tag, " result_valid"}, result_valid, 0);
    check({tag, " sel_bits"}, sel_bits, 0);
    check({tag, " R_y"}, R_y, 8'h01);
    check({tag, " result"}, result, 0);
    check_taps(tag);
  endtask

  // One full transaction: accept, START, 2^N RUN cycles, HOLD for `hold` cycles
  // with result_ready low, then handshake. abort_at >= 0 resets mid-RUN instead.
  task automatic run_frame(input int unsigned s, input int hold, input int abort_at,
                           input int forced_acc, input bit b2b);
    int unsigned exp_res;
    exp_res = 0;
    result_ready = 1'b0;
    check("idle sample_ready", sample_ready, 1);
    sample_valid = 1'b1;
    sample_in    = (N+1)'(s);
    step();
    for (int i = TAPS - 1; i > 0; i--) model_taps[i] = model_taps[i-1];
    model_taps[0] = int'(s);

    check("start pulse", start, 1);
    check("start sel_bits", sel_bits, 0);
    check("start sample_ready", sample_ready, 0);
    check("start result_valid", result_valid, 0);
    if (b2b) check("start spacing", cyc - last_start, FRAME + 3);
    last_start = cyc;
    check_taps("start");
    sample_valid = 1'($urandom);
    sample_in    = (N+1)'($urandom);
    step();

    for (int k = 0; k < FRAME; k++) begin
      check("run sel_bits", sel_bits, k);
      check("run R_y", R_y, lfsr_seq[k]);
      if (k < 4) check($sformatf("lfsr first[%0d]", k), R_y, lfsr_known[k]);
      if (k > 0 && k < FRAME - 1) check("lfsr early repeat", R_y == 8'h01, 0);
      check("run start", start, 0);
      check("run result_valid", result_valid, 0);
      check("run sample_ready", sample_ready, 0);
      if (k == abort_at) begin
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_reset_state("midrun reset");
        $display("frame sample=0x%03h aborted by reset at sel_bits=0x%02h", s, k);
        return;
      end
      if (k == FRAME - 1 && forced_acc >= 0) acc_out = (N+1)'(forced_acc);
      else                                   acc_out = (N+1)'($urandom_range(0, FRAME - 1));
      if (k == FRAME - 1) exp_res = acc_out;
      sample_valid = 1'($urandom);
      sample_in    = (N+1)'($urandom);
      step();
    end

    check("valid latency", cyc - last_start, FRAME + 1);
    sample_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      check("hold result_valid", result_valid, 1);
      check("hold result", result, exp_res);
      check("hold sample_ready", sample_ready, 0);
      check("hold start", start, 0);
      check("hold sel_bits", sel_bits, 0);
      acc_out = (N+1)'($urandom_range(0, FRAME - 1));
      step();
    end
    check("handshake result_valid", result_valid, 1);
    check("handshake result", result, exp_res);
    check_taps("hold");
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    sample_valid = 1'b0;
    check("post result_valid", result_valid, 0);
    check("post sample_ready", sample_ready, 1);
    $display("frame sample=0x%03h result=0x%03h hold=%0d", s, result, hold);
  endtask

  initial begin
    int r;
    int prev_hold;
    r = 8'h01;
    for (int k = 0; k < FRAME; k++) begin
      lfsr_seq[k] = r;
      r = (r & 1) ? ((r >> 1) ^ 8'hB8) : (r >> 1);
    end
    lfsr_known[0] = 8'h01; lfsr_known[1] = 8'hB8;
    lfsr_known[2] = 8'h5C; lfsr_known[3] = 8'h2E;
    for (int i = 0; i < TAPS; i++) taps3[i] = 0;
    taps3[0] = 9'h033; taps3[1] = 9'h022; taps3[2] = 9'h011;

    reset_n = 1'b0;
    step();
    step();
    check_reset_state("power-on reset");
    reset_n = 1'b1;
    step();

    run_frame($urandom_range(0, 511), 0, 8'h40, -1, 1'b0);
    run_frame(9'h011, 0, -1, -1, 1'b0);
    run_frame(9'h022, 0, -1, -1, 1'b1);
    run_frame(9'h033, 0, -1, -1, 1'b1);
    for (int i = 0; i < TAPS; i++)
      check($sformatf("three-sample taps[%0d]", i), taps[i], taps3[i]);

    run_frame($urandom_range(0, 511), 10, -1, 9'h03A, 1'b1);
    prev_hold = 10;
    for (int f = 0; f < 5; f++) begin
      int h;
      h = $urandom_range(0, 4);
      run_frame($urandom_range(0, 511), h, -1, -1, prev_hold == 0);
      prev_hold = h;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_fir_sequencer.md
# sc_fir_sequencer

Upstream control stage of the stochastic-computing FIR datapath. It buffers incoming binary samples in a 39-tap delay line and sequences one stochastic frame per sample. For each frame it drives the accumulator's `in`, `start`, `sel_bits` and `R_y` inputs, with `R_y` taken from an internal LFSR. At frame end it captures the accumulator count and returns it to the consumer over a valid/ready handshake.

## Interface
Parameters:
- `N`, 8: stochastic resolution; must equal `` `n``; frame length 2^N.
- `LFSR_MASK`, 8'hB8: Galois feedback mask, N bits, maximal-length.
- `LFSR_SEED`, 8'h01: LFSR reset/frame-start value; nonzero.

Ports (`clock`, `reset_n` first):
- `clock`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on `clock`.
- `sample_in`  in  N+1  new binary input sample.
- `sample_valid`  in  1  `sample_in` is valid.
- `sample_ready`  out  1  block accepts a sample this cycle.
- `taps[38:0]`  out  N+1 each  delay line; `taps[0]` is newest; drives accumulator `in`.
- `start`  out  1  one-cycle accumulator clear.
- `sel_bits`  out  N  frame cycle counter; drives accumulator `sel_bits`.
- `R_y`  out  N  LFSR random number.
- `acc_out`  in  N+1  accumulator `out`.
- `result`  out  N+1  captured frame count.
- `result_valid`  out  1  `result` is valid.
- `result_ready`  in  1  consumer accepts `result`.

## Operation
States: IDLE, START, RUN, HOLD.
- **IDLE**
  - `sample_ready`=1.
  - On `sample_valid`: shift the delay line (`taps[i]`<=`taps[i-1]` for i=38..1, `taps[0]`<=`sample_in`), then go to START.
- **START**
  - One cycle. `start`=1, `sel_bits`=0.
  - LFSR reloads `LFSR_SEED`. Next state RUN.
- **RUN**
  - `sel_bits` increments by 1 each cycle, from 0 to 2^N-1.
  - LFSR advances every RUN cycle: if lsb=1, `R_y`<=(`R_y`>>1)^`LFSR_MASK`, else `R_y`<=`R_y`>>1.
  - In the cycle where `sel_bits`=2^N-1, capture `result`<=`acc_out` (count of bits for `sel_bits` 0..2^N-2), then go to HOLD.
  - The accumulator self-clears on its own `done`; the sequencer does not depend on that clear.
- **HOLD**
  - `result_valid`=1 and `result` held stable until `result_ready`=1.
  - On the handshake cycle go to IDLE; `result_valid` drops the next cycle.

Invariants:
- `taps` change only on an IDLE accept; they are stable from START through HOLD.
- `sample_ready`=0 outside IDLE. Samples offered then are not consumed and must be held by the upstream source.
- Outside RUN, `sel_bits` stays 0 and the LFSR holds its value.
- No arithmetic is done here. `result` is an unsigned N+1-bit copy of `acc_out`, with no wrap (maximum 2^N-1).

## Timing
Reset (`reset_n`=0 at an edge) forces:
- state IDLE;
- all `taps`=0, `sel_bits`=0, `R_y`=`LFSR_SEED`, `result`=0;
- `start`=0, `result_valid`=0, `sample_ready`=1 from the next cycle.

Reset has priority over every event, including mid-RUN and mid-HOLD; a pending result is discarded.

Latency for a sample accepted at edge T:
- START during cycle T+1.
- RUN during cycles T+2 .. T+1+2^N.
- `result_valid` from cycle T+2+2^N.
- N=8: RUN is cycles T+2..T+257; valid at T+258.

Other timing rules:
- Back-to-back throughput: one sample per 2^N+3 cycles when `result_ready` is tied high.
- `result_valid` with `result_ready` high in the same cycle is a completed transfer; the next sample can be accepted one cycle later, in IDLE.
- `sample_valid` held high in HOLD has no effect.
- `start` is asserted exactly one cycle per frame and never in IDLE or HOLD.

## Test plan
- Reset mid-RUN at `sel_bits`=0x40: next cycle shows IDLE, `taps` all 0, `R_y`=0x01, `sel_bits`=0, `result_valid`=0, `sample_ready`=1.
- Push samples 0x011, 0x022, 0x033 with `result_ready`=1: after the third frame, `taps[0]`=0x033, `taps[1]`=0x022, `taps[2]`=0x011, `taps[3..38]`=0.
- LFSR sequence after START: `R_y` reads 0x01, 0xB8, 0x5C, 0x2E in the first four RUN cycles, and period 255 is checked over a frame.
- Accept at T with N=8: `start`=1 only in cycle T+1; `sel_bits`=0 at T+2 and 255 at T+257; `result_valid` rises at T+258.
- Model `acc_out`=0x3A at `sel_bits`=255, then `result_ready`=0 for 10 cycles: `result`=0x3A stable with `result_valid`=1 for all 10 cycles; `sample_valid`=1 in HOLD is ignored and `taps` are unchanged.
- `result_ready`=1 on the first valid cycle, `sample_valid` held high: the next sample is accepted 1 cycle after the handshake; spacing between `start` pulses is 259 cycles.
